// File: rtl/board_multi_operand_accumulator.sv
// Switch-operand accumulator: N W-bit switch channels are summed serially, one per clock,
// then loaded into or added onto a saturating/wrapping accumulator shown on the LEDs.
module board_multi_operand_accumulator #(
  parameter int W          = 4,
  parameter int N          = 4,
  parameter int ACC_W      = 8,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int SAT        = 1
) (
  input  logic               CLK100MHZ,
  input  logic               BTNC,
  input  logic [N*W-1:0]     SW,
  input  logic               BTNU,
  input  logic               BTNR,
  output logic [ACC_W+1:0]   LED
);

  localparam int IW = $clog2(N);
  localparam int PW = W + $clog2(N);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SUM, COMMIT} state_t;

  logic [N*W-1:0] sw_s1, sw_s2;
  logic [1:0]     btn_s1, btn_s2, lvl, lvl_d, pulse;
  logic [CW-1:0]  cnt [2];

  // bit 0 = LOAD (BTNU), bit 1 = ACCUMULATE (BTNR)
  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      lvl    <= '0;
      lvl_d  <= '0;
      pulse  <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
      btn_s1 <= {BTNR, BTNU};
      btn_s2 <= btn_s1;
      lvl_d  <= lvl;
      pulse  <= lvl & ~lvl_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (btn_s2[i] != lvl[i]) begin
          if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
            lvl[i] <= btn_s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  state_t           state;
  logic [W-1:0]     ops [N];
  logic [PW-1:0]    partial;
  logic [IW-1:0]    idx;
  logic             op_load;
  logic [ACC_W-1:0] acc;
  logic             ovf, busy;
  logic [ACC_W:0]   acc_sum;

  always_comb begin
    acc_sum = {1'b0, acc} + (ACC_W+1)'(partial);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      state   <= IDLE;
      partial <= '0;
      idx     <= '0;
      op_load <= 1'b0;
      acc     <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      for (int unsigned i = 0; i < N; i++) ops[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse[0] | pulse[1]) begin
            for (int unsigned i = 0; i < N; i++) ops[i] <= sw_s2[i*W +: W];
            partial <= '0;
            idx     <= '0;
            op_load <= pulse[0];
            busy    <= 1'b1;
            state   <= SUM;
          end
        end
        SUM: begin
          partial <= partial + PW'(ops[idx]);
          idx     <= idx + IW'(1);
          if (idx == IW'(N - 1)) state <= COMMIT;
        end
        COMMIT: begin
          if (op_load) begin
            acc <= ACC_W'(partial);
            ovf <= 1'b0;
          end else if (acc_sum[ACC_W]) begin
            ovf <= 1'b1;
            acc <= (SAT != 0) ? '1 : acc_sum[ACC_W-1:0];
          end else begin
            acc <= acc_sum[ACC_W-1:0];
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign LED = {busy, ovf, acc};

endmodule

// File: tb/tb_board_multi_operand_accumulator.sv
// Bench for board_multi_operand_accumulator: a saturating and a wrapping instance share the
// same stimulus; directed steps plus random operations are checked against an arithmetic model.
module tb_board_multi_operand_accumulator;

  logic        clk = 1'b0;
  logic        btnc, btnu, btnr;
  logic [15:0] sw;
  logic [9:0]  led_s, led_w;

  always #5 clk = ~clk;

  board_multi_operand_accumulator #(.W(4), .N(4), .ACC_W(8), .DEB_CYCLES(4), .SAT(1)) u_sat (
    .CLK100MHZ(clk), .BTNC(btnc), .SW(sw), .BTNU(btnu), .BTNR(btnr), .LED(led_s)
  );

  board_multi_operand_accumulator #(.W(4), .N(4), .ACC_W(8), .DEB_CYCLES(4), .SAT(0)) u_wrap (
    .CLK100MHZ(clk), .BTNC(btnc), .SW(sw), .BTNU(btnu), .BTNR(btnr), .LED(led_w)
  );

  int checks = 0;
  int errors = 0;
  int m_acc [2];
  bit m_ovf [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // index 0 = saturating instance, 1 = wrapping instance
  function automatic void model_op(input bit is_load, input logic [15:0] s);
    int sum = 0;
    for (int i = 0; i < 4; i++) sum += int'(s[4*i +: 4]);
    for (int k = 0; k < 2; k++) begin
      if (is_load) begin
        m_acc[k] = sum;
        m_ovf[k] = 1'b0;
      end else begin
        int t = m_acc[k] + sum;
        if (t > 255) begin
          m_ovf[k] = 1'b1;
          m_acc[k] = (k == 0) ? 255 : t - 256;
        end else begin
          m_acc[k] = t;
        end
      end
    end
  endfunction

  task automatic chk_led(input string tag);
    chk({tag, " sat led"},  {22'd0, led_s}, {22'd0, 1'b0, m_ovf[0], 8'(m_acc[0])});
    chk({tag, " wrap led"}, {22'd0, led_w}, {22'd0, 1'b0, m_ovf[1], 8'(m_acc[1])});
  endtask

  // Press buttons, check pulse latency and busy length, release, then check the result.
  task automatic op(input string tag, input bit ld, input bit ac, input int ac_late,
                    input logic [15:0] s, input logic [15:0] s_mid);
    int lat = 0;
    int bc = 0;
    bit seen = 1'b0;
    @(negedge clk);
    sw   = s;
    btnu = ld;
    btnr = ac && (ac_late == 0);
    while (lat < 40 && !seen) begin
      @(negedge clk);
      lat++;
      if (ac && ac_late == lat) btnr = 1'b1;
      seen = led_s[9];
    end
    chk({tag, " latency"}, lat, 8);
    sw = s_mid;
    while (led_s[9] && bc < 40) begin
      bc++;
      @(negedge clk);
    end
    chk({tag, " busy length"}, bc, 5);
    model_op(ld, s);
    btnu = 1'b0;
    btnr = 1'b0;
    repeat (12) @(negedge clk);
    chk_led(tag);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    bit busy_seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (led_s[9] || led_w[9]) busy_seen = 1'b1;
    end
    chk({tag, " no op started"}, busy_seen, 0);
    chk_led(tag);
  endtask

  initial begin
    logic [15:0] rs;
    int          kind;
    int          guard;

    m_acc[0] = 0; m_acc[1] = 0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;

    btnc = 1'b1; btnu = 1'b1; btnr = 1'b1; sw = 16'hFFFF;
    repeat (2) begin
      @(negedge clk);
      chk_led("reset held");
    end
    btnc = 1'b0; btnu = 1'b0; btnr = 1'b0;
    @(negedge clk);
    chk_led("reset released");
    idle_watch("post reset", 15);

    op("load 4321", 1, 0, 0, 16'h4321, 16'h4321);

    op("load ffff", 1, 0, 0, 16'hFFFF, 16'hFFFF);
    op("acc 2",     0, 1, 0, 16'hFFFF, 16'hFFFF);
    op("acc 3",     0, 1, 0, 16'hFFFF, 16'hFFFF);
    op("acc 4",     0, 1, 0, 16'hFFFF, 16'hFFFF);
    op("acc 5 ovf", 0, 1, 0, 16'hFFFF, 16'hFFFF);
    op("acc 6 ovf", 0, 1, 0, 16'hFFFF, 16'hFFFF);
    op("load 0001", 1, 0, 0, 16'h0001, 16'h0001);

    repeat (4) begin
      @(negedge clk); btnr = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk); btnr = 1'b0;
      repeat (2) @(negedge clk);
    end
    idle_watch("bounce", 12);

    op("pulse in busy", 1, 1, 2, 16'h0102, 16'h0102);
    op("both pulses",   1, 1, 0, 16'h1111, 16'h1111);
    op("sw mid sum",    0, 1, 0, 16'h2222, 16'hFFFF);

    op("pre reset load", 1, 0, 0, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    sw = 16'hFFFF; btnr = 1'b1;
    guard = 0;
    while (!led_s[9] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("mid reset busy seen", led_s[9], 1);
    @(negedge clk);
    btnc = 1'b1;
    @(negedge clk);
    m_acc[0] = 0; m_acc[1] = 0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
    chk_led("mid reset");
    btnc = 1'b0; btnr = 1'b0;
    idle_watch("after mid reset", 15);
    op("reload 4321", 1, 0, 0, 16'h4321, 16'h4321);

    for (int i = 0; i < 16; i++) begin
      rs   = 16'($urandom);
      kind = int'($urandom_range(0, 2));
      op("random", kind != 1, kind != 0, 0, rs, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_multi_operand_accumulator.md
# board_multi_operand_accumulator

Board-level, parametrised successor to the four-operand switch adder. It takes N unsigned W-bit operands from the slide switches and adds them with a serial adder FSM, one channel per clock. Debounced push-buttons either load the sum into an accumulator register or add it to the accumulator. The accumulator has a selectable saturate or wrap overflow policy, and its value drives the LEDs. It sits directly under the board top, fed by CLK100MHZ, the switches and the buttons.

## Interface
Parameters:
- W, 4: operand width per channel.
- N, 4: number of operand channels (N ≥ 2). Channel i = SW[i*W +: W].
- ACC_W, 8: accumulator width. Must satisfy ACC_W ≥ W + clog2(N).
- DEB_CYCLES, 1_000_000: consecutive stable cycles required by the button debouncer (10 ms at 100 MHz).
- SAT, 1: 1 = saturate at 2^ACC_W−1; 0 = wrap modulo 2^ACC_W.

Ports:
- CLK100MHZ  input  1  system clock. The only clock.
- BTNC  input  1  reset, synchronous, active-high.
- SW  input  N*W  operand switches. Asynchronous, so they are synchronised internally.
- BTNU  input  1  LOAD button (raw): acc ← sum.
- BTNR  input  1  ACCUMULATE button (raw): acc ← acc + sum.
- LED  output  ACC_W+2  LED[ACC_W-1:0] = accumulator, LED[ACC_W] = sticky overflow, LED[ACC_W+1] = busy.

## Operation
- Input conditioning
  - SW, BTNU and BTNR each pass through a 2-flop synchroniser.
  - Each button feeds its own debouncer. The debounced level changes only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - A rising edge of a debounced level produces a one-cycle pulse: ld_p or acc_p.
- FSM states: IDLE, SUM, COMMIT.
  - IDLE, on ld_p or acc_p:
    - Snapshot the synchronised SW into an operand register.
    - partial ← 0, idx ← 0.
    - op ← LOAD if ld_p is high, else ACC. LOAD wins when both pulses arrive together.
    - Go to SUM.
  - SUM: partial ← partial + operand[idx], idx ← idx+1. After the N-th addition go to COMMIT.
  - COMMIT:
    - LOAD: acc ← partial, ovf ← 0.
    - ACC: compute acc + partial at ACC_W+1 bits. On carry-out set ovf, and set acc to 2^ACC_W−1 (SAT=1) or to the low ACC_W bits (SAT=0). With no carry, ovf is unchanged.
    - Then go to IDLE.
- Pulses arriving in SUM or COMMIT are dropped, not queued.
- SW changes after the snapshot do not affect the operation in progress.
- partial is W+clog2(N) bits wide and never overflows.
- ovf is sticky. It clears only on reset or on a LOAD commit.

## Timing
- Reset (BTNC high at a clock edge):
  - All outputs go to 0 (acc, ovf, busy), state = IDLE.
  - Debouncer counters and levels clear to 0. Synchroniser flops clear to 0.
  - Reset during SUM or COMMIT aborts the operation. acc is not updated from the aborted operation.
- Button latency: from the first raw high cycle, the pulse appears after 2 synchroniser cycles + DEB_CYCLES + 1 edge-detect cycle, assuming the input is clean.
- With the pulse in cycle t:
  - State = SUM during cycles t+1 … t+N.
  - State = COMMIT at cycle t+N+1.
  - The new acc/ovf is visible on LED from cycle t+N+2.
- busy (LED[ACC_W+1]) is high from cycle t+1 through t+N+1, i.e. exactly N+1 cycles.
- A pulse in cycle t+N+2 or later is accepted (back-to-back operations allowed).
- All outputs are registered. There is no combinational path from SW or the buttons to LED.

## Test plan
Use W=4, N=4, ACC_W=8, DEB_CYCLES=4.
- Reset: hold BTNC for 2 cycles with SW=16'hFFFF and both buttons high → LED=10'h000 while reset is held and on the cycle after release. No pulse until a debounced rising edge occurs.
- Load: SW=16'h4321, BTNU clean press → pulse after 2+4+1 cycles, busy high for exactly 5 cycles, then LED[7:0]=8'h0A, ovf=0.
- Accumulate/saturate (SAT=1): SW=16'hFFFF, load once and then accumulate 3 times → acc = 60, 120, 180, 240. A 5th accumulate gives acc=255, ovf=1. A later load with SW=16'h0001 gives acc=1, ovf=0.
- Wrap (SAT=0): same sequence → 5th accumulate gives acc=44 (300−256), ovf=1. A 6th accumulate gives 104 with ovf still 1.
- Debounce/ignore:
  - BTNR toggled with high periods of 3 cycles → no pulse, LED unchanged.
  - A pulse during busy is ignored.
  - BTNU and BTNR pulses in the same cycle → LOAD performed.
  - SW changed mid-SUM → result uses the snapshot.
- Reset mid-operation: assert BTNC at the 2nd SUM cycle after acc=60 → acc=0, busy=0, ovf=0, state IDLE. The next load of 16'h4321 gives 10.
